// File: rtl/viterbi_pkg.sv
// Shared constants, state encoding and branch-label helper for the
// K=7 rate-1/2 Viterbi ACS scheduler.
package viterbi_pkg;

    localparam int NUM_STATES = 64;
    localparam int NUM_BFLY   = 32;
    localparam logic [6:0] G0 = 7'o133;
    localparam logic [6:0] G1 = 7'o171;
    localparam int M_DEF = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WAIT,
        S_RUN,
        S_WRAP
    } state_e;

    // All-ones metric of an (m+1)-bit path metric: saturated / unreachable.
    function automatic int unsigned pm_sat(input int unsigned m);
        return (32'd1 << (m + 1)) - 32'd1;
    endfunction

    // Coded pair {g1,g0} emitted when in_bit is shifted in from 'state'.
    function automatic logic [1:0] exp(input logic [5:0] state, input logic in_bit);
        logic [6:0] r;
        r = {in_bit, state};
        return {^(r & G1), ^(r & G0)};
    endfunction

endpackage

// File: rtl/viterbi_acs_scheduler_if.sv
// Symbol handshake, ACS lane bus and survivor output of the scheduler.
interface viterbi_acs_scheduler_if #(
    parameter int M = 6,
    parameter int P = 4
);
    logic                 sym_valid;
    logic [1:0]           sym;
    logic                 sym_ready;
    logic [P*(M+1)-1:0]   acs_pm_a;
    logic [P*(M+1)-1:0]   acs_pm_b;
    logic [2*P-1:0]       acs_exp;
    logic [1:0]           acs_sym;
    logic [P*(M+1)-1:0]   acs_new_lo;
    logic [P*(M+1)-1:0]   acs_new_hi;
    logic [P-1:0]         acs_dec_lo;
    logic [P-1:0]         acs_dec_hi;
    logic                 surv_valid;
    logic [63:0]          surv_bits;

    modport master (
        input  sym_valid, sym, acs_new_lo, acs_new_hi, acs_dec_lo, acs_dec_hi,
        output sym_ready, acs_pm_a, acs_pm_b, acs_exp, acs_sym, surv_valid, surv_bits
    );

    modport slave (
        output sym_valid, sym, acs_new_lo, acs_new_hi, acs_dec_lo, acs_dec_hi,
        input  sym_ready, acs_pm_a, acs_pm_b, acs_exp, acs_sym, surv_valid, surv_bits
    );
endinterface

// File: rtl/pm_bank.sv
// Ping-pong path-metric store: reads come from rd_bank_i, writes land in the
// other bank, and init_i loads both banks with the frame-start metrics.
module pm_bank
    import viterbi_pkg::*;
#(
    parameter int M = M_DEF,
    parameter int P = 4
) (
    input  logic                clk,
    input  logic                init_i,
    input  logic                rd_bank_i,
    input  logic [P-1:0][5:0]   rd_addr_a_i,
    input  logic [P-1:0][5:0]   rd_addr_b_i,
    output logic [P-1:0][M:0]   rd_data_a_o,
    output logic [P-1:0][M:0]   rd_data_b_o,
    input  logic                wr_en_i,
    input  logic [P-1:0][5:0]   wr_addr_lo_i,
    input  logic [P-1:0][5:0]   wr_addr_hi_i,
    input  logic [P-1:0][M:0]   wr_data_lo_i,
    input  logic [P-1:0][M:0]   wr_data_hi_i
);

    logic [M:0] mem_q [2][NUM_STATES];

    // NOTE: the banks carry no reset; a frame start always rewrites every entry
    // before it is read, so a reset branch would only add muxing to each cell.
    always_ff @(posedge clk) begin
        if (init_i) begin
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < NUM_STATES; s++) begin
                    mem_q[b][s] <= {(M+1){s != 0}};
                end
            end
        end else if (wr_en_i) begin
            for (int l = 0; l < P; l++) begin
                mem_q[~rd_bank_i][wr_addr_lo_i[l]] <= wr_data_lo_i[l];
                mem_q[~rd_bank_i][wr_addr_hi_i[l]] <= wr_data_hi_i[l];
            end
        end
    end

    always_comb begin
        for (int l = 0; l < P; l++) begin
            rd_data_a_o[l] = mem_q[rd_bank_i][rd_addr_a_i[l]];
            rd_data_b_o[l] = mem_q[rd_bank_i][rd_addr_b_i[l]];
        end
    end

endmodule

// File: rtl/viterbi_acs_scheduler.sv
// Walks the 32 trellis butterflies over P ACS lanes per received bit pair,
// owns the metric banks, normalization and survivor hand-off.
module viterbi_acs_scheduler
    import viterbi_pkg::*;
#(
    parameter int M = M_DEF,
    parameter int P = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame_start_i,
    viterbi_acs_scheduler_if.master        acs_if,
    output logic [15:0]                    step_cnt_o,
    output logic                           busy_o
);

    localparam int W = M + 1;
    localparam int NCYC = NUM_BFLY / P;
    localparam logic [M:0] SAT = W'(pm_sat(M));
    localparam logic [M:0] NORM_OFS = W'(1 << M);

    state_e state_q, state_d;
    logic [4:0]  cyc_q, cyc_d;
    logic        bank_q, bank_d;
    logic        norm_q, norm_d;
    logic [M:0]  min_q, min_d, lane_min;
    logic [15:0] step_q, step_d;
    logic [1:0]  sym_q, sym_d;
    logic [63:0] surv_q, surv_d;
    logic        last_cyc;

    logic [P-1:0][4:0] bfly;
    logic [P-1:0][5:0] rd_addr_a, rd_addr_b, wr_addr_lo, wr_addr_hi;
    logic [P-1:0][M:0] rd_pm_a, rd_pm_b, new_lo, new_hi;

    assign new_lo   = acs_if.acs_new_lo;
    assign new_hi   = acs_if.acs_new_hi;
    assign last_cyc = (cyc_q == 5'(NCYC - 1));

    // Lane l of cycle c serves butterfly j = c*P + l: reads 2j/2j+1, writes j/j+32.
    always_comb begin
        for (int l = 0; l < P; l++) begin
            bfly[l]       = 5'(int'(cyc_q) * P + l);
            rd_addr_a[l]  = {bfly[l], 1'b0};
            rd_addr_b[l]  = {bfly[l], 1'b1};
            wr_addr_lo[l] = {1'b0, bfly[l]};
            wr_addr_hi[l] = {1'b1, bfly[l]};
        end
    end

    pm_bank #(.M(M), .P(P)) u_pm_bank (
        .clk          (clk),
        .init_i       (state_q == S_INIT),
        .rd_bank_i    (bank_q),
        .rd_addr_a_i  (rd_addr_a),
        .rd_addr_b_i  (rd_addr_b),
        .rd_data_a_o  (rd_pm_a),
        .rd_data_b_o  (rd_pm_b),
        .wr_en_i      (state_q == S_RUN),
        .wr_addr_lo_i (wr_addr_lo),
        .wr_addr_hi_i (wr_addr_hi),
        .wr_data_lo_i (new_lo),
        .wr_data_hi_i (new_hi)
    );

    function automatic logic [M:0] norm_rd(input logic [M:0] m, input logic nrm);
        return (nrm && m != SAT) ? m - NORM_OFS : m;
    endfunction

    // NOTE: state lives only in always_ff blocks assigned with <=, so every
    // register samples the pre-edge values of all the others.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (frame_start_i) state_d = S_INIT;
            S_INIT: state_d = S_WAIT;
            S_WAIT: begin
                if (frame_start_i)         state_d = S_INIT;
                else if (acs_if.sym_valid) state_d = S_RUN;
            end
            S_RUN: begin
                if (frame_start_i) state_d = S_INIT;
                else if (last_cyc) state_d = S_WRAP;
            end
            S_WRAP: state_d = frame_start_i ? S_INIT : S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        acs_if.sym_ready  = (state_q == S_WAIT);
        acs_if.surv_valid = (state_q == S_WRAP) && !frame_start_i;
        busy_o            = (state_q != S_IDLE);
        acs_if.acs_pm_a   = '0;
        acs_if.acs_pm_b   = '0;
        acs_if.acs_exp    = '0;
        if (state_q == S_RUN) begin
            for (int l = 0; l < P; l++) begin
                acs_if.acs_pm_a[l*W +: W] = norm_rd(rd_pm_a[l], norm_q);
                acs_if.acs_pm_b[l*W +: W] = norm_rd(rd_pm_b[l], norm_q);
                acs_if.acs_exp[2*l +: 2]  = exp(rd_addr_a[l], 1'b0);
            end
        end
    end

    assign acs_if.acs_sym   = sym_q;
    assign acs_if.surv_bits = surv_q;
    assign step_cnt_o       = step_q;

    always_comb begin
        lane_min = SAT;
        for (int l = 0; l < P; l++) begin
            if (new_lo[l] < lane_min) lane_min = new_lo[l];
            if (new_hi[l] < lane_min) lane_min = new_hi[l];
        end
    end

    always_comb begin
        cyc_d  = cyc_q;
        bank_d = bank_q;
        norm_d = norm_q;
        min_d  = min_q;
        step_d = step_q;
        sym_d  = sym_q;
        surv_d = surv_q;
        unique case (state_q)
            S_INIT: begin
                step_d = '0;
                norm_d = 1'b0;
                bank_d = 1'b0;
            end
            S_WAIT: begin
                if (acs_if.sym_valid && !frame_start_i) begin
                    sym_d = acs_if.sym;
                    cyc_d = '0;
                    min_d = SAT;
                end
            end
            S_RUN: begin
                cyc_d = cyc_q + 5'd1;
                min_d = (lane_min < min_q) ? lane_min : min_q;
                for (int l = 0; l < P; l++) begin
                    surv_d[{1'b0, bfly[l]}] = acs_if.acs_dec_lo[l];
                    surv_d[{1'b1, bfly[l]}] = acs_if.acs_dec_hi[l];
                end
            end
            S_WRAP: begin
                if (!frame_start_i) begin
                    bank_d = ~bank_q;
                    step_d = step_q + 16'd1;
                    norm_d = (min_q >= NORM_OFS);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q  <= '0;
            bank_q <= 1'b0;
            norm_q <= 1'b0;
            min_q  <= '0;
            step_q <= '0;
            sym_q  <= '0;
            surv_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            bank_q <= bank_d;
            norm_q <= norm_d;
            min_q  <= min_d;
            step_q <= step_d;
            sym_q  <= sym_d;
            surv_q <= surv_d;
        end
    end

endmodule

// File: doc/viterbi_acs_scheduler.md
Name: viterbi_acs_scheduler

Overview:
- Sequences the Viterbi add-compare-select (ACS) datapath of the 802.11a rate-1/2 decoder (K=7, 64 states, generators 133o/171o).
- Owns the ping-pong path-metric banks.
- Per accepted received bit pair, walks the 32 trellis butterflies over P combinational ACS lanes, P butterflies per cycle.
- Writes the new metrics, applies normalization, and hands the 64 survivor decisions of each trellis step to the traceback unit.

Parameters:
- M, 6, path metric width is M+1 bits; metric all-ones = saturated/unreachable.
- P, 4, butterflies (ACS lane pairs) per cycle; must divide 32 (1,2,4,8,16,32).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  pulse; re-initialises metrics for a new frame.
- sym_valid  in  1  received bit pair valid.
- sym  in  2  received hard bits {b1,b0} (b0 from g0=133o).
- sym_ready  out  1  scheduler can accept sym this cycle.
- acs_pm_a  out  P*(M+1)  normalized old metric of state 2j per lane.
- acs_pm_b  out  P*(M+1)  normalized old metric of state 2j+1 per lane.
- acs_exp  out  2*P  expected coded pair of transition 2j->j per lane.
- acs_sym  out  2  latched received pair driven to all lanes.
- acs_new_lo  in  P*(M+1)  new metric of state j per lane (combinational return).
- acs_new_hi  in  P*(M+1)  new metric of state j+32 per lane.
- acs_dec_lo  in  P  decision for state j (1 = came from 2j+1).
- acs_dec_hi  in  P  decision for state j+32.
- surv_valid  out  1  one-cycle pulse: surv_bits is complete.
- surv_bits  out  64  decision bit per new state.
- step_cnt  out  16  trellis steps completed since frame_start (wraps).
- busy  out  1  high outside IDLE.

Behaviour:
- Reset: state IDLE; sym_ready=0, surv_valid=0, surv_bits=0, step_cnt=0, busy=0, bank=0, norm=0, acs_* outputs=0.
- Both banks are left uninitialised by reset. A frame_start is required before the first symbol.
- Lane mapping: in cycle c, lane l serves butterfly j=c*P+l, c=0..32/P-1.
- Expected-bit mapping: the expected pair of transition 2j->j is exp(2j,0). The expected pairs of the other three transitions are derived in the lanes by the complement rule.
- States: IDLE, INIT, WAIT, RUN, WRAP.
- IDLE -> INIT on frame_start.
- INIT (1 cycle): write both banks; state 0 = 0, states 1..63 = all-ones. Then step_cnt=0, norm=0, go to WAIT.
- WAIT: sym_ready=1. On sym_valid, latch sym into acs_sym, clear cycle counter c, go to RUN.
- RUN (32/P cycles): drive the lanes from the read bank. In the same cycle, capture the returns into the write bank at states j and j+32, and the decisions into the surv_bits shadow register.
- Latency: sym accept to surv_valid = 32/P+1 cycles; P=4 gives 9.
- Normalization:
  - During RUN, track min over all new metrics written this step.
  - In WRAP, if min >= 2^M, set norm=1 for the next step. Every read is then reduced by 2^M, saturating: all-ones stays all-ones.
  - Otherwise norm=0.
- WRAP (1 cycle): toggle bank, pulse surv_valid with surv_bits, increment step_cnt (16-bit wrap), go to WAIT.
- Throughput: one symbol per 32/P+2 cycles; WRAP and WAIT each cost one cycle.
- frame_start in WAIT, RUN or WRAP aborts the current step: go to INIT next cycle, no surv_valid, the partial step is discarded.
- frame_start and sym_valid in the same WAIT cycle: frame_start wins and sym is not accepted (sym_ready is still 1; the source must hold sym).
- rst mid-RUN returns to IDLE next edge; no surv_valid is emitted.
- sym_valid while sym_ready=0 is ignored; the source holds sym.
- Lane-return saturation is owned by the lanes. The scheduler stores returns unmodified.

Decomposition:
- Package viterbi_pkg: NUM_STATES=64, NUM_BFLY=32, G0=7'o133, G1=7'o171, function exp(state, bit) returning 2 bits, M default, the metric saturation constant, and the state enum.
- Sub-module pm_bank: dual-bank 64x(M+1) register file. P pairs of read ports and P pairs of write ports, plus a bulk-init input.
- Scheduler FSM, counters, min tracker and normalization stay in viterbi_acs_scheduler.

Test Plan:
- rst, then frame_start -> 1 cycle later bank0 reads pm[0]=0, pm[1..63]=127 (M=6); step_cnt=0; sym_ready=1 in WAIT.
- Reference-model lanes, sym=2'b00 accepted -> surv_valid exactly 9 cycles later; pm[0]=0 and pm[32]=2 after WRAP; step_cnt=1.
- 200 random symbols against a bit-exact software ACS -> surv_bits and all 64 metrics match every step; norm asserts whenever min>=64; no metric wraps below 0.
- Hold sym_valid=1 continuously -> sym_ready high one cycle every 10 cycles; exactly one surv_valid per accepted symbol.
- frame_start in RUN cycle 3 -> no surv_valid for that step, INIT next cycle, step_cnt=0, metrics reinitialised.
- frame_start coincident with sym_valid in WAIT -> symbol not consumed, INIT taken; rst in RUN -> IDLE, busy=0, surv_valid never pulses.
